rnn_sequencer: RTL and testbench
================================

// Module: rnn_sequencer
// PURPOSE
//  Upstream driver of the RNN accelerator slave. Buffers a stream of character codes and looks each
//  one up in an on-chip embedding table. Writes each vector into the accelerator over its Avalon
//  slave port and triggers a recurrent step. On the last character it runs dense + readback and
//  presents the signed 16-bit result on a valid/ready output. Replaces per-char C-side MMIO.
// PARAMETERS
//  EMB_BITS      2   log2 embedding length (EMB_LEN=4); must equal the accelerator's input-vector bits
//  VOCAB_BITS    7   log2 vocabulary size (128 codes)
//  FIFO_BITS     3   log2 char FIFO depth (8 entries)
//  TIMEOUT_BITS  16  poll counter width; a poll that runs 2^TIMEOUT_BITS-1 cycles is an error
// PORTS
//  clk       in   1    system clock (single clock domain)
//  rst_n     in   1    asynchronous, active-low reset
//  ch_valid  in   1    char code valid
//  ch_ready  out  1    FIFO not full
//  ch_data   in   VOCAB_BITS  char code
//  ch_last   in   1    char ends the sequence
//  emb_we    in   1    embedding table write strobe
//  emb_addr  in   VOCAB_BITS+EMB_BITS  {code, element}
//  emb_wdata in   16   Q8.8 signed element
//  m_read    out  1    Avalon read to accelerator
//  m_write   out  1    Avalon write to accelerator
//  m_addr    out  3    Avalon address
//  m_wdata   out  32   [23:16] element index, [15:0] value
//  m_rdata   in   32   accelerator data_out (combinational, same-cycle)
//  res_valid out  1    result held
//  res_ready in   1    consumer accepts result
//  res_data  out  16   signed result
//  busy      out  1    state != IDLE or FIFO non-empty
//  err       out  1    sticky poll timeout
// BEHAVIOUR
//  Reset: all outputs 0 except ch_ready=1. FIFO empty, state IDLE, err=0, table contents undefined.
//  FIFO: entries are {last,code}. Push when ch_valid&&ch_ready; ch_ready=0 when full, even if a pop
//   happens that cycle. Pop only in IDLE when non-empty. Push+pop in the same cycle keeps the count.
//  Table: 1-cycle synchronous read. A same-cycle write to the same address returns the old data.
//   Writes are legal at any time.
//  Master: at most one of m_read/m_write per cycle, one beat, no waitrequest. m_rdata is sampled in
//   the same cycle as m_read. Polling cycles m_read=1 every cycle.
//  FSM:
//   IDLE: FIFO non-empty -> pop, latch last, issue table read for element 0 -> FETCH.
//   FETCH: wait 1 cycle for data -> LOADV.
//   LOADV: write addr 1, m_wdata={8'b0,idx,value}, idx 0..EMB_LEN-1, one per cycle.
//    The table read is pipelined so the writes run back-to-back. After idx EMB_LEN-1 -> START.
//   START: write addr 0, data 0 -> WLOAD.
//   WLOAD: read addr 1 until m_rdata[0]=1, which is seen no earlier than 2 cycles after START.
//    Then last=0 -> IDLE; last=1 -> DREQ.
//   DREQ: write addr 7 -> WVALID.
//   WVALID: read addr 0 until m_rdata[0]=1 -> RDRES.
//   RDRES: read addr 7, capture m_rdata[15:0] to res_data. This read clears the hidden state -> WCLR.
//   WCLR: read addr 1 until m_rdata[0]=1, so no write lands in the accelerator's CLEAR cycle -> RESP.
//   RESP: res_valid=1, res_data stable until res_valid&&res_ready. FIFO keeps filling. Then -> IDLE.
//  Never read addr 7 outside RDRES; that read has a side effect.
//  Timeout: the counter resets on entry to each poll state. On saturation: err<=1, FIFO flushed -> IDLE.
//   err clears only on rst_n. The accelerator is then in an unknown state; the host must reset both.
//  Empty-FIFO IDLE issues no bus traffic.
//  A sequence of one char with last=1 is legal.
//  Asserting rst_n mid-sequence aborts immediately. The accelerator is assumed to share rst_n.
//  Minimum per-char cost: 1+1+EMB_LEN+1+2 cycles plus accelerator compute time.
// TESTING
//  1 Reset: rst_n low mid-LOADV -> m_write=0, res_valid=0, ch_ready=1 on the next edge; busy=0.
//  2 Table: code 5 = {0x0100,0xFF00,0x0080,0x0000}, push 5 last=1.
//    -> writes addr1 0x00000100, 0x0001FF00, 0x00020080, 0x00030000 back-to-back, then addr0.
//  3 Sequence of 3 chars into the real accelerator model -> exactly 3 addr-0 writes and 1 addr-7 write.
//    res_data matches the golden C model bit-exact.
//  4 Backpressure: hold res_ready=0 for 50 cycles, push 8 chars -> res_data stable, ch_ready=0 after 8.
//    The next sequence starts only after the handshake.
//  5 Timeout: stub slave returns m_rdata=0, TIMEOUT_BITS=4 -> err=1 at 15 poll cycles, FIFO empty, IDLE.
//  6 Protocol monitor on all tests -> never m_read&&m_write, no write between RDRES and WCLR exit.

Source files
------------

// File: rtl/rnn_sequencer_if.sv
// Signal bundle between the RNN sequencer and its environment: char stream, embedding-table
// write port, Avalon master to the accelerator, result stream and status.
interface rnn_sequencer_if #(
    parameter int unsigned VOCAB_BITS = 7,
    parameter int unsigned EMB_BITS   = 2
);
    logic                           ch_valid;
    logic                           ch_ready;
    logic [VOCAB_BITS-1:0]          ch_data;
    logic                           ch_last;
    logic                           emb_we;
    logic [VOCAB_BITS+EMB_BITS-1:0] emb_addr;
    logic [15:0]                    emb_wdata;
    logic                           m_read;
    logic                           m_write;
    logic [2:0]                     m_addr;
    logic [31:0]                    m_wdata;
    logic [31:0]                    m_rdata;
    logic                           res_valid;
    logic                           res_ready;
    logic [15:0]                    res_data;
    logic                           busy;
    logic                           err;

    modport master (
        input  ch_valid, ch_data, ch_last, emb_we, emb_addr, emb_wdata, m_rdata, res_ready,
        output ch_ready, m_read, m_write, m_addr, m_wdata, res_valid, res_data, busy, err
    );

    modport slave (
        output ch_valid, ch_data, ch_last, emb_we, emb_addr, emb_wdata, m_rdata, res_ready,
        input  ch_ready, m_read, m_write, m_addr, m_wdata, res_valid, res_data, busy, err
    );
endinterface

// File: rtl/rnn_sequencer.sv
// Feeds buffered character codes through an embedding table into the RNN accelerator, then runs
// dense + readback on the last char and holds the signed result on a valid/ready output.
module rnn_sequencer #(
    parameter int unsigned EMB_BITS     = 2,
    parameter int unsigned VOCAB_BITS   = 7,
    parameter int unsigned FIFO_BITS    = 3,
    parameter int unsigned TIMEOUT_BITS = 16
) (
    input logic             clk,
    input logic             rst_n,
    rnn_sequencer_if.master bus
);
    localparam int unsigned EMB_LEN = 1 << EMB_BITS;
    localparam int unsigned DEPTH   = 1 << FIFO_BITS;
    localparam int unsigned AW      = VOCAB_BITS + EMB_BITS;

    typedef enum logic [3:0] {
        StIdle, StFetch, StLoadv, StStart, StWload, StDreq, StWvalid, StRdres, StWclr, StResp
    } state_e;

    state_e                  state_q, state_d;
    logic [VOCAB_BITS:0]     fifo_mem [DEPTH];
    logic [FIFO_BITS-1:0]    wr_ptr_q, rd_ptr_q;
    logic [FIFO_BITS:0]      count_q;
    logic                    last_q, last_d;
    logic [VOCAB_BITS-1:0]   code_q, code_d;
    logic [EMB_BITS-1:0]     idx_q, idx_d;
    logic [TIMEOUT_BITS-1:0] tmo_q, tmo_d;
    logic                    err_q, err_d;
    logic [15:0]             res_q, res_d;
    logic [15:0]             tbl_mem [2**AW];
    logic [15:0]             tbl_rdata;
    logic [AW-1:0]           tbl_addr;
    logic                    full, push, pop, flush;
    logic [VOCAB_BITS:0]     head;

    assign full         = (count_q == (FIFO_BITS+1)'(DEPTH));
    assign push         = bus.ch_valid && !full;
    assign head         = fifo_mem[rd_ptr_q];
    assign bus.ch_ready = !full;
    assign bus.busy     = (state_q != StIdle) || (count_q != '0);
    assign bus.err      = err_q;
    assign bus.res_data = res_q;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {bus.ch_last, bus.ch_data};
    end

    // Same-address write and read in one cycle returns the old word.
    always_ff @(posedge clk) begin
        if (bus.emb_we) tbl_mem[bus.emb_addr] <= bus.emb_wdata;
        tbl_rdata <= tbl_mem[tbl_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + FIFO_BITS'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_BITS'(1);
            if (push && !pop)      count_q <= count_q + (FIFO_BITS+1)'(1);
            else if (!push && pop) count_q <= count_q - (FIFO_BITS+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            last_q  <= 1'b0;
            code_q  <= '0;
            idx_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        code_d        = code_q;
        idx_d         = idx_q;
        tmo_d         = tmo_q;
        err_d         = err_q;
        res_d         = res_q;
        pop           = 1'b0;
        flush         = 1'b0;
        tbl_addr      = {code_q, idx_q};
        bus.m_read    = 1'b0;
        bus.m_write   = 1'b0;
        bus.m_addr    = 3'd0;
        bus.m_wdata   = 32'd0;
        bus.res_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop      = 1'b1;
                    last_d   = head[VOCAB_BITS];
                    code_d   = head[VOCAB_BITS-1:0];
                    idx_d    = '0;
                    tbl_addr = {head[VOCAB_BITS-1:0], EMB_BITS'(0)};
                    state_d  = StFetch;
                end
            end
            // Re-read element 0 so the LOADV pipeline always sees element idx in tbl_rdata.
            StFetch: state_d = StLoadv;
            StLoadv: begin
                bus.m_write = 1'b1;
                bus.m_addr  = 3'd1;
                bus.m_wdata = {8'd0, 8'(idx_q), tbl_rdata};
                tbl_addr    = {code_q, idx_q + EMB_BITS'(1)};
                if (idx_q == EMB_BITS'(EMB_LEN - 1)) state_d = StStart;
                else idx_d = idx_q + EMB_BITS'(1);
            end
            StStart: begin
                bus.m_write = 1'b1;
                state_d     = StWload;
            end
            // The done flag is not trusted in the first poll cycle after a step starts.
            StWload: begin
                bus.m_read = 1'b1;
                bus.m_addr = 3'd1;
                if (bus.m_rdata[0] && tmo_q != TIMEOUT_BITS'(1)) begin
                    state_d = last_q ? StDreq : StIdle;
                end
            end
            StDreq: begin
                bus.m_write = 1'b1;
                bus.m_addr  = 3'd7;
                state_d     = StWvalid;
            end
            StWvalid: begin
                bus.m_read = 1'b1;
                if (bus.m_rdata[0]) state_d = StRdres;
            end
            StRdres: begin
                bus.m_read = 1'b1;
                bus.m_addr = 3'd7;
                res_d      = bus.m_rdata[15:0];
                state_d    = StWclr;
            end
            StWclr: begin
                bus.m_read = 1'b1;
                bus.m_addr = 3'd1;
                if (bus.m_rdata[0]) state_d = StResp;
            end
            StResp: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if ((state_q inside {StWload, StWvalid, StWclr}) && state_d == state_q) begin
            if (tmo_q == {TIMEOUT_BITS{1'b1}}) begin
                err_d   = 1'b1;
                flush   = 1'b1;
                state_d = StIdle;
            end else begin
                tmo_d = tmo_q + TIMEOUT_BITS'(1);
            end
        end
        if (state_d != state_q && (state_d inside {StWload, StWvalid, StWclr})) begin
            tmo_d = TIMEOUT_BITS'(1);
        end
    end
endmodule

// File: tb/tb_rnn_sequencer.sv
// Directed bench for rnn_sequencer with a small behavioural accelerator: each step adds the
// vector elements to a 16-bit hidden sum, dense returns that sum, and the result read clears it.
module tb_rnn_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rnn_sequencer_if #(.VOCAB_BITS(7), .EMB_BITS(2)) bus ();

    rnn_sequencer #(
        .EMB_BITS(2), .VOCAB_BITS(7), .FIFO_BITS(3), .TIMEOUT_BITS(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Accelerator stand-in
    bit          stall = 1'b0;
    logic [15:0] vec [4];
    logic [15:0] h, res;
    logic        done, valid;
    int          step_cnt, dense_cnt, clr_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0; res <= '0; done <= 1'b0; valid <= 1'b0;
            step_cnt <= 0; dense_cnt <= 0; clr_cnt <= 0;
        end else begin
            if (step_cnt == 1) begin
                h    <= h + vec[0] + vec[1] + vec[2] + vec[3];
                done <= 1'b1;
            end
            if (step_cnt > 0) step_cnt <= step_cnt - 1;
            if (dense_cnt == 1) begin
                res   <= h;
                valid <= 1'b1;
            end
            if (dense_cnt > 0) dense_cnt <= dense_cnt - 1;
            if (clr_cnt == 1) done <= 1'b1;
            if (clr_cnt > 0) clr_cnt <= clr_cnt - 1;
            if (bus.m_write) begin
                case (bus.m_addr)
                    3'd1: vec[bus.m_wdata[17:16]] <= bus.m_wdata[15:0];
                    3'd0: begin step_cnt <= 3; done <= 1'b0; end
                    3'd7: begin dense_cnt <= 2; valid <= 1'b0; end
                    default: ;
                endcase
            end
            if (bus.m_read && bus.m_addr == 3'd7) begin
                h <= '0; valid <= 1'b0; done <= 1'b0; clr_cnt <= 2;
            end
        end
    end

    always_comb begin
        bus.m_rdata = 32'd0;
        if (!stall) begin
            case (bus.m_addr)
                3'd1:    bus.m_rdata = {31'd0, done};
                3'd0:    bus.m_rdata = {31'd0, valid};
                3'd7:    bus.m_rdata = {16'd0, res};
                default: bus.m_rdata = 32'd0;
            endcase
        end
    end

    // Bus monitor
    int         cycle = 0;
    int         n_start = 0, n_dense = 0, n_poll1 = 0, n_rd7 = 0, proto_err = 0;
    logic [2:0]  wlog_addr [$];
    logic [31:0] wlog_data [$];
    int          wlog_cyc  [$];
    logic        in_clear;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (bus.m_read && bus.m_write) proto_err <= proto_err + 1;
        if (bus.m_write && in_clear) proto_err <= proto_err + 1;
        if (bus.m_write) begin
            wlog_addr.push_back(bus.m_addr);
            wlog_data.push_back(bus.m_wdata);
            wlog_cyc.push_back(cycle);
            if (bus.m_addr == 3'd0) n_start <= n_start + 1;
            if (bus.m_addr == 3'd7) n_dense <= n_dense + 1;
        end
        if (bus.m_read && bus.m_addr == 3'd1) n_poll1 <= n_poll1 + 1;
        if (bus.m_read && bus.m_addr == 3'd7) n_rd7 <= n_rd7 + 1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_clear <= 1'b0;
        else if (bus.m_read && bus.m_addr == 3'd7) in_clear <= 1'b1;
        else if (in_clear && bus.m_read && bus.m_addr == 3'd1 && bus.m_rdata[0]) in_clear <= 1'b0;
    end

    // Stimulus helpers (all called at a negedge, return at a negedge)
    task automatic tbl_write(input logic [6:0] code, input logic [1:0] idx, input logic [15:0] v);
        bus.emb_we    = 1'b1;
        bus.emb_addr  = {code, idx};
        bus.emb_wdata = v;
        @(negedge clk);
        bus.emb_we = 1'b0;
    endtask

    task automatic push(input logic [6:0] code, input logic last);
        int n = 0;
        bus.ch_valid = 1'b1;
        bus.ch_data  = code;
        bus.ch_last  = last;
        while (!bus.ch_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ch_ready) begin
            n_checks++;
            $display("FAIL push_timeout: ch_ready=%b required 1", bus.ch_ready);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        bus.ch_valid = 1'b0;
    endtask

    task automatic wait_res(input int budget, output bit ok);
        int n = 0;
        while (!bus.res_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = bus.res_valid;
        if (!ok) begin
            n_checks++;
            $display("FAIL res_valid_timeout: res_valid=%b required 1", bus.res_valid);
        end
    endtask

    task automatic accept();
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        int n = 0;
        n_checks++;
        if ({bus.m_read, bus.m_write, bus.res_valid, bus.ch_ready, bus.busy, bus.err} !== 6'b000100)
            $display("FAIL reset_outputs: rd,wr,rv,rdy,busy,err=%b required 000100",
                     {bus.m_read, bus.m_write, bus.res_valid, bus.ch_ready, bus.busy, bus.err});
        else n_pass++;
        n_checks++;
        if (bus.res_data !== 16'h0000) $display("FAIL reset_res_data: %h required 0000", bus.res_data);
        else n_pass++;

        for (int i = 0; i < 4; i++) tbl_write(7'd9, 2'(i), 16'h0001);
        push(7'd9, 1'b0);
        while (!(bus.m_write && bus.m_addr == 3'd1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!(bus.m_write && bus.m_addr == 3'd1)) $display("FAIL reset_reach_loadv: not reached");
        else n_pass++;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.m_write, bus.res_valid, bus.ch_ready, bus.busy} !== 4'b0010)
            $display("FAIL reset_mid_loadv: wr,rv,rdy,busy=%b required 0010",
                     {bus.m_write, bus.res_valid, bus.ch_ready, bus.busy});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_table();
        logic [34:0] exp_w [5];
        int s;
        bit ok;
        exp_w = '{{3'd1, 32'h00000100}, {3'd1, 32'h0001FF00}, {3'd1, 32'h00020080},
                  {3'd1, 32'h00030000}, {3'd0, 32'h00000000}};
        tbl_write(7'd5, 2'd0, 16'h0100);
        tbl_write(7'd5, 2'd1, 16'hFF00);
        tbl_write(7'd5, 2'd2, 16'h0080);
        tbl_write(7'd5, 2'd3, 16'h0000);
        s = wlog_addr.size();
        push(7'd5, 1'b1);
        wait_res(300, ok);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({wlog_addr[s+i], wlog_data[s+i]} !== exp_w[i])
                $display("FAIL table_write%0d: addr %0d data %h required addr %0d data %h", i,
                         wlog_addr[s+i], wlog_data[s+i], exp_w[i][34:32], exp_w[i][31:0]);
            else n_pass++;
        end
        n_checks++;
        if (wlog_cyc[s+4] - wlog_cyc[s] !== 4)
            $display("FAIL table_back_to_back: span %0d cycles required 4",
                     wlog_cyc[s+4] - wlog_cyc[s]);
        else n_pass++;
        n_checks++;
        if (bus.res_data !== 16'h0080) $display("FAIL table_result: %h required 0080", bus.res_data);
        else n_pass++;
        accept();
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL table_idle: busy=%b required 0", bus.busy);
        else n_pass++;
    endtask

    task automatic test_sequence();
        int s0, d0;
        bit ok;
        tbl_write(7'd1, 2'd0, 16'h0001);
        tbl_write(7'd1, 2'd1, 16'h0002);
        tbl_write(7'd1, 2'd2, 16'h0003);
        tbl_write(7'd1, 2'd3, 16'h0004);
        tbl_write(7'd2, 2'd0, 16'h0010);
        tbl_write(7'd2, 2'd1, 16'h0000);
        tbl_write(7'd2, 2'd2, 16'h0000);
        tbl_write(7'd2, 2'd3, 16'h0000);
        tbl_write(7'd3, 2'd0, 16'hFFFF);
        tbl_write(7'd3, 2'd1, 16'h0000);
        tbl_write(7'd3, 2'd2, 16'h0000);
        tbl_write(7'd3, 2'd3, 16'h0000);
        s0 = n_start;
        d0 = n_dense;
        push(7'd1, 1'b0);
        push(7'd2, 1'b0);
        push(7'd3, 1'b1);
        wait_res(500, ok);
        n_checks++;
        if (n_start - s0 !== 3) $display("FAIL seq_starts: %0d required 3", n_start - s0);
        else n_pass++;
        n_checks++;
        if (n_dense - d0 !== 1) $display("FAIL seq_dense: %0d required 1", n_dense - d0);
        else n_pass++;
        n_checks++;
        if (bus.res_data !== 16'h0019) $display("FAIL seq_result: %h required 0019", bus.res_data);
        else n_pass++;
        accept();
    endtask

    task automatic test_backpressure();
        int s0, bad = 0, n = 0;
        bit ok;
        push(7'd2, 1'b1);
        wait_res(300, ok);
        s0 = n_start;
        for (int i = 0; i < 8; i++) push(7'd1, 1'b1);
        n_checks++;
        if (bus.ch_ready !== 1'b0) $display("FAIL bp_full: ch_ready=%b required 0", bus.ch_ready);
        else n_pass++;
        for (int i = 0; i < 50; i++) begin
            if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h0010) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad !== 0) $display("FAIL bp_stable: %0d unstable cycles required 0", bad);
        else n_pass++;
        n_checks++;
        if (n_start - s0 !== 0) $display("FAIL bp_no_start: %0d starts required 0", n_start - s0);
        else n_pass++;
        accept();
        for (int i = 0; i < 8; i++) begin
            wait_res(300, ok);
            n_checks++;
            if (bus.res_data !== 16'h000A)
                $display("FAIL bp_result%0d: %h required 000a", i, bus.res_data);
            else n_pass++;
            accept();
        end
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL bp_drain: busy=%b required 0", bus.busy);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int p0, w0, n = 0;
        stall = 1'b1;
        p0 = n_poll1;
        push(7'd1, 1'b0);
        push(7'd2, 1'b1);
        while (!bus.err && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (bus.err !== 1'b1) $display("FAIL tmo_err: err=%b required 1", bus.err);
        else n_pass++;
        n_checks++;
        if (n_poll1 - p0 !== 15) $display("FAIL tmo_polls: %0d required 15", n_poll1 - p0);
        else n_pass++;
        n_checks++;
        if ({bus.busy, bus.ch_ready} !== 2'b01)
            $display("FAIL tmo_flushed: busy,rdy=%b required 01", {bus.busy, bus.ch_ready});
        else n_pass++;
        w0 = wlog_addr.size();
        repeat (10) @(negedge clk);
        n_checks++;
        if ({bus.err, bus.m_read, bus.m_write} !== 3'b100 || wlog_addr.size() !== w0)
            $display("FAIL tmo_sticky_quiet: err,rd,wr=%b writes=%0d required 100 and 0",
                     {bus.err, bus.m_read, bus.m_write}, wlog_addr.size() - w0);
        else n_pass++;
    endtask

    initial begin
        bus.ch_valid  = 1'b0;
        bus.ch_data   = '0;
        bus.ch_last   = 1'b0;
        bus.emb_we    = 1'b0;
        bus.emb_addr  = '0;
        bus.emb_wdata = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_table();
        test_sequence();
        test_backpressure();
        test_timeout();
        n_checks++;
        if (proto_err !== 0) $display("FAIL protocol: %0d violations required 0", proto_err);
        else n_pass++;
        n_checks++;
        if (n_rd7 !== n_dense) $display("FAIL result_reads: %0d required %0d", n_rd7, n_dense);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
